// File: rtl/freq_synth.sv
// freq_synth: programmable square-wave synthesizer driven by a fractional phase accumulator
// Ports: clk, reset_n (async, active-low); freq_in/load capture a pending frequency (Hz, clamped to CLK_HZ/2);
// start/stop control the run; wave is the registered output, p_edge marks its first high cycle,
// running is high outside IDLE, pending flags a loaded frequency not yet applied.
// FREQ_SYNTH_BURST_EN adds burst_len (rising edges per burst, 0 = continuous) and burst_done.
module freq_synth #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BITS = 25
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [BITS-1:0] freq_in,
  input  logic            load,
  input  logic            start,
  input  logic            stop,
`ifdef FREQ_SYNTH_BURST_EN
  input  logic [15:0]     burst_len,
  output logic            burst_done,
`endif
  output logic            wave,
  output logic            p_edge,
  output logic            running,
  output logic            pending
);
  localparam int AW = $clog2(CLK_HZ) + 2;
  localparam logic [AW-1:0] MOD = AW'(CLK_HZ);
  localparam logic [BITS-1:0] FMAX = BITS'(CLK_HZ / 2);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state;
  logic [AW-1:0] acc, inc, sum;
  logic [BITS-1:0] f_active, f_pend;
  logic tog, rise, fall, apply, hit;
  // a new frequency is only applied when wave is (or becomes) low, so a high half is never cut short
  always_comb begin
    inc = AW'({f_active, 1'b0});
    sum = acc + inc;
    tog = (state != IDLE) && (sum >= MOD);
    rise = tog && !wave;
    fall = tog && wave;
    apply = pending && (fall || (!wave && !tog));
  end
  assign running = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      acc <= '0;
      f_active <= '0;
      f_pend <= '0;
      wave <= 1'b0;
      p_edge <= 1'b0;
      pending <= 1'b0;
    end else begin
      pending <= load || (pending && !apply);
      if (load) f_pend <= (freq_in > FMAX) ? FMAX : freq_in;
      if (apply) f_active <= f_pend;
      p_edge <= rise;
      if (state != IDLE) begin
        acc <= tog ? sum - MOD : sum;
        wave <= wave ^ tog;
      end
      case (state)
        IDLE: if (start && !stop) state <= RUN;
        RUN:
          if (stop && !(wave ^ tog)) begin
            state <= IDLE;
            acc <= '0;
          end else if (stop || hit) state <= STOPPING;
        STOPPING:
          if (fall) begin
            state <= IDLE;
            acc <= '0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef FREQ_SYNTH_BURST_EN
  logic [15:0] blen, nrise;
  logic bflag;
  // the edge that completes the burst sends RUN into STOPPING; bflag remembers why we stopped
  assign hit = (state == RUN) && rise && (blen != 16'd0) && (nrise + 16'd1 == blen);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blen <= '0;
      nrise <= '0;
      bflag <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= (state == STOPPING) && fall && bflag;
      if (state == IDLE) begin
        blen <= burst_len;
        nrise <= '0;
        bflag <= 1'b0;
      end else begin
        if (rise) nrise <= nrise + 16'd1;
        if (hit) bflag <= 1'b1;
      end
    end
`else
  assign hit = 1'b0;
`endif
endmodule
